// File: rtl/irq_ctrl.sv
// irq_ctrl: vectored interrupt controller with nested in-service tracking and fixed priority (channel 0 highest).
// Define IRQ_CTRL_DEBOUNCE_EN to add a per-channel stable-level filter of DEBOUNCE_CYCLES cycles.
module irq_ctrl #(
  parameter int CHANNELS = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 8,
  localparam int VW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] in,
  input  logic [CHANNELS-1:0] ie,
  input  logic                ack,
  input  logic                reti,
  output logic                irq,
  output logic [VW-1:0]       vector,
  output logic [CHANNELS-1:0] pending,
  output logic [CHANNELS-1:0] in_service
);
  if (CHANNELS < 1 || CHANNELS > 16 || SYNC_STAGES < 1 || DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("irq_ctrl: illegal parameter values");
  end
  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] lvl, prev, rise, elig, ack_mask, reti_mask;
  logic                blocked;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
`ifdef IRQ_CTRL_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [CW-1:0] cnt [CHANNELS];
  // lvl follows sync only once it has disagreed for DEBOUNCE_CYCLES consecutive cycles
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      lvl <= '0;
      for (int c = 0; c < CHANNELS; c++) cnt[c] <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++)
        if (sync_q[SYNC_STAGES-1][c] == lvl[c]) cnt[c] <= '0;
        else if (cnt[c] == CNT_LAST) begin
          lvl[c] <= sync_q[SYNC_STAGES-1][c];
          cnt[c] <= '0;
        end else cnt[c] <= cnt[c] + 1'b1;
    end
`else
  assign lvl = sync_q[SYNC_STAGES-1];
`endif
  assign rise = lvl & ~prev;
  // an in-service channel blocks itself and everything of lower priority
  always_comb begin
    blocked = 1'b0;
    elig = '0;
    vector = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      blocked = blocked | in_service[c];
      elig[c] = pending[c] & ie[c] & ~blocked;
    end
    for (int c = CHANNELS - 1; c >= 0; c--) if (elig[c]) vector = VW'(c);
  end
  assign irq = |elig;
  assign ack_mask = (ack && irq) ? elig & (~elig + CHANNELS'(1)) : '0;
  assign reti_mask = reti ? in_service & (~in_service + CHANNELS'(1)) : '0;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      prev <= '0;
      pending <= '0;
      in_service <= '0;
    end else begin
      prev <= lvl;
      pending <= (pending & ~ack_mask) | rise;
      in_service <= (in_service & ~reti_mask) | ack_mask;
    end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: table-driven scoreboard bench for irq_ctrl (CHANNELS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=8).
module tb_irq_ctrl;
`ifdef IRQ_CTRL_DEBOUNCE_EN
  localparam int LAT = 2 + 8 + 1;
`else
  localparam int LAT = 2 + 1;
`endif
  typedef struct {
    string       nm;
    logic [3:0]  in;
    logic [3:0]  ie;
    logic        ack;
    logic        reti;
    int          cyc;
    logic [3:0]  p;
    logic [3:0]  s;
    logic        irq;
    logic [1:0]  v;
  } row_t;
  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] in_v, ie_v, pending, in_service;
  logic       ack, reti, irq;
  logic [1:0] vector;
  int         n_chk = 0;
  int         n_fail = 0;
  row_t       sb[$];
  row_t       rows[32];
  irq_ctrl dut (
    .clock(clock), .reset(reset), .in(in_v), .ie(ie_v), .ack(ack), .reti(reti),
    .irq(irq), .vector(vector), .pending(pending), .in_service(in_service)
  );
  always #5 clock = ~clock;
  task automatic check(input string nm, input logic [3:0] p, input logic [3:0] s, input logic i, input logic [1:0] v);
    n_chk++;
    if (pending !== p || in_service !== s || irq !== i || vector !== v) begin
      n_fail++;
      $display("FAIL %s: got pending=%b in_service=%b irq=%b vector=%0d, expected pending=%b in_service=%b irq=%b vector=%0d",
               nm, pending, in_service, irq, vector, p, s, i, v);
    end
  endtask
  task automatic run_row(input row_t r);
    row_t e;
    in_v = r.in;
    ie_v = r.ie;
    ack = r.ack;
    reti = r.reti;
    sb.push_back(r);
    for (int k = 0; k < r.cyc; k++) begin
      @(posedge clock);
      @(negedge clock);
      ack = 1'b0;
      reti = 1'b0;
    end
    e = sb.pop_front();
    check(e.nm, e.p, e.s, e.irq, e.v);
  endtask
  initial begin
    reset = 1'b0;
    in_v = '0;
    ie_v = 4'hF;
    ack = 1'b0;
    reti = 1'b0;
    rows = '{
      '{"req_early",  4'b0100, 4'hF,    1'b0, 1'b0, LAT-1, 4'b0000, 4'b0000, 1'b0, 2'd0},
      '{"req",        4'b0100, 4'hF,    1'b0, 1'b0, 1,     4'b0100, 4'b0000, 1'b1, 2'd2},
      '{"ack2",       4'b0000, 4'hF,    1'b1, 1'b0, 1,     4'b0000, 4'b0100, 1'b0, 2'd0},
      '{"reti2",      4'b0000, 4'hF,    1'b0, 1'b1, LAT,   4'b0000, 4'b0000, 1'b0, 2'd0},
      '{"prio",       4'b1010, 4'hF,    1'b0, 1'b0, LAT,   4'b1010, 4'b0000, 1'b1, 2'd1},
      '{"ack1",       4'b0000, 4'hF,    1'b1, 1'b0, 1,     4'b1000, 4'b0010, 1'b0, 2'd0},
      '{"reti1",      4'b0000, 4'hF,    1'b0, 1'b1, 1,     4'b1000, 4'b0000, 1'b1, 2'd3},
      '{"ack3",       4'b0000, 4'hF,    1'b1, 1'b0, LAT,   4'b0000, 4'b1000, 1'b0, 2'd0},
      '{"reti3",      4'b0000, 4'hF,    1'b0, 1'b1, 1,     4'b0000, 4'b0000, 1'b0, 2'd0},
      '{"req2",       4'b0100, 4'hF,    1'b0, 1'b0, LAT,   4'b0100, 4'b0000, 1'b1, 2'd2},
      '{"ack2b",      4'b0000, 4'hF,    1'b1, 1'b0, LAT,   4'b0000, 4'b0100, 1'b0, 2'd0},
      '{"nest_req0",  4'b0001, 4'hF,    1'b0, 1'b0, LAT,   4'b0001, 4'b0100, 1'b1, 2'd0},
      '{"ack0",       4'b0000, 4'hF,    1'b1, 1'b0, LAT,   4'b0000, 4'b0101, 1'b0, 2'd0},
      '{"reti_inner", 4'b0000, 4'hF,    1'b0, 1'b1, 1,     4'b0000, 4'b0100, 1'b0, 2'd0},
      '{"reti_outer", 4'b0000, 4'hF,    1'b0, 1'b1, 1,     4'b0000, 4'b0000, 1'b0, 2'd0},
      '{"masked_req", 4'b0010, 4'h0,    1'b0, 1'b0, LAT,   4'b0010, 4'b0000, 1'b0, 2'd0},
      '{"spur_ack",   4'b0000, 4'h0,    1'b1, 1'b0, 1,     4'b0010, 4'b0000, 1'b0, 2'd0},
      '{"unmask",     4'b0000, 4'b0010, 1'b0, 1'b0, 1,     4'b0010, 4'b0000, 1'b1, 2'd1},
      '{"ack1b",      4'b0000, 4'hF,    1'b1, 1'b0, 1,     4'b0000, 4'b0010, 1'b0, 2'd0},
      '{"reti1b",     4'b0000, 4'hF,    1'b0, 1'b1, LAT,   4'b0000, 4'b0000, 1'b0, 2'd0},
      '{"req1",       4'b0010, 4'hF,    1'b0, 1'b0, LAT,   4'b0010, 4'b0000, 1'b1, 2'd1},
      '{"drop1",      4'b0000, 4'hF,    1'b0, 1'b0, LAT,   4'b0010, 4'b0000, 1'b1, 2'd1},
      '{"rerise1",    4'b0010, 4'hF,    1'b0, 1'b0, LAT-1, 4'b0010, 4'b0000, 1'b1, 2'd1},
      '{"rise_ack",   4'b0010, 4'hF,    1'b1, 1'b0, 1,     4'b0010, 4'b0010, 1'b0, 2'd0},
      '{"reti1c",     4'b0000, 4'hF,    1'b0, 1'b1, 1,     4'b0010, 4'b0000, 1'b1, 2'd1},
      '{"ack1c",      4'b0000, 4'hF,    1'b1, 1'b0, LAT,   4'b0000, 4'b0010, 1'b0, 2'd0},
      '{"reti1d",     4'b0000, 4'hF,    1'b0, 1'b1, 1,     4'b0000, 4'b0000, 1'b0, 2'd0},
      '{"req2c",      4'b0100, 4'hF,    1'b0, 1'b0, LAT,   4'b0100, 4'b0000, 1'b1, 2'd2},
      '{"ack2c",      4'b0000, 4'hF,    1'b1, 1'b0, LAT,   4'b0000, 4'b0100, 1'b0, 2'd0},
      '{"req0c",      4'b0001, 4'hF,    1'b0, 1'b0, LAT,   4'b0001, 4'b0100, 1'b1, 2'd0},
      '{"ack_reti",   4'b0000, 4'hF,    1'b1, 1'b1, 1,     4'b0000, 4'b0001, 1'b0, 2'd0},
      '{"reti0c",     4'b0000, 4'hF,    1'b0, 1'b1, LAT,   4'b0000, 4'b0000, 1'b0, 2'd0}
    };
    repeat (2) @(negedge clock);
    check("reset_state", 4'b0000, 4'b0000, 1'b0, 2'd0);
    reset = 1'b1;
    for (int r = 0; r < 32; r++) run_row(rows[r]);
    run_row('{"ie_setup", 4'b0010, 4'h0, 1'b0, 1'b0, LAT, 4'b0010, 4'b0000, 1'b0, 2'd0});
    ie_v = 4'b0010;
    #1 check("ie_comb_on", 4'b0010, 4'b0000, 1'b1, 2'd1);
    ie_v = 4'b0000;
    #1 check("ie_comb_off", 4'b0010, 4'b0000, 1'b0, 2'd0);
    run_row('{"ack_before_rst", 4'b0000, 4'hF, 1'b1, 1'b0, LAT, 4'b0000, 4'b0010, 1'b0, 2'd0});
    run_row('{"pend_before_rst", 4'b1001, 4'hF, 1'b0, 1'b0, LAT, 4'b1001, 4'b0010, 1'b1, 2'd0});
    @(posedge clock);
    #2 reset = 1'b0;
    #1 check("async_reset", 4'b0000, 4'b0000, 1'b0, 2'd0);
    in_v = 4'b1000;
    repeat (2) @(negedge clock);
    check("reset_held", 4'b0000, 4'b0000, 1'b0, 2'd0);
    reset = 1'b1;
    run_row('{"held_early", 4'b1000, 4'hF, 1'b0, 1'b0, LAT-1, 4'b0000, 4'b0000, 1'b0, 2'd0});
    run_row('{"held_rise", 4'b1000, 4'hF, 1'b0, 1'b0, 1, 4'b1000, 4'b0000, 1'b1, 2'd3});
    run_row('{"held_once", 4'b1000, 4'hF, 1'b1, 1'b0, 2*LAT, 4'b0000, 4'b1000, 1'b0, 2'd0});
    run_row('{"held_reti", 4'b0000, 4'hF, 1'b0, 1'b1, LAT, 4'b0000, 4'b0000, 1'b0, 2'd0});
`ifdef IRQ_CTRL_DEBOUNCE_EN
    run_row('{"glitch", 4'b0001, 4'hF, 1'b0, 1'b0, 5, 4'b0000, 4'b0000, 1'b0, 2'd0});
    run_row('{"glitch_gone", 4'b0000, 4'hF, 1'b0, 1'b0, LAT+2, 4'b0000, 4'b0000, 1'b0, 2'd0});
    run_row('{"stable_early", 4'b0001, 4'hF, 1'b0, 1'b0, LAT-1, 4'b0000, 4'b0000, 1'b0, 2'd0});
    run_row('{"stable_rise", 4'b0001, 4'hF, 1'b0, 1'b0, 1, 4'b0001, 4'b0000, 1'b1, 2'd0});
    run_row('{"stable_hold", 4'b0001, 4'hF, 1'b0, 1'b0, 20-LAT, 4'b0001, 4'b0000, 1'b1, 2'd0});
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
